eth_tlp_decap: RTL and testbench

//  Receive-side counterpart of the TLP-over-Ethernet transmit path. Consumes the 10G MAC RX
//  AXI-Stream on clk156. Checks each frame's 16-byte header: DA(6) SA(6) EtherType(2) Seq(2).

---
 rtl/eth_tlp_decap.sv | 124 ++++++++++++
 tb/tb_eth_tlp_decap.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/eth_tlp_decap.sv
// Receive-side TLP-over-Ethernet decapsulator: filters each frame's 16-byte header and
// forwards the 64-bit payload beats into the RX FIFO write port.
module eth_tlp_decap #(
    parameter logic [47:0] LOCAL_MAC    = 48'h00_0A_35_00_00_01,
    parameter logic        ACCEPT_BCAST = 1'b1,
    parameter logic [15:0] ETHERTYPE    = 16'h88B5
) (
    input  logic        clk156,
    input  logic        sys_rst,
    input  logic        s_axis_tvalid,
    input  logic [63:0] s_axis_tdata,
    input  logic [7:0]  s_axis_tkeep,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    output logic        wr_en,
    output logic [73:0] din,
    input  logic        full,
    output logic [31:0] frm_ok_cnt,
    output logic [31:0] frm_drop_cnt,
    output logic [15:0] seq_err_cnt,
    output logic [15:0] last_seq
);

    localparam int DATA_W = 64;
    localparam logic [73:0] TERMINATOR = {1'b1, 1'b1, 8'h00, {DATA_W{1'b0}}};

    typedef enum logic [1:0] {HDR0, HDR1, PAYLOAD, DROP} state_t;

    state_t      state;
    logic        da_match;
    logic        abort_pend;
    logic        exp_seq_valid;
    logic [15:0] exp_seq;

    // Byte 0 of the wire is the most significant octet of the MAC address.
    function automatic logic dest_match(input logic [DATA_W-1:0] d);
        logic [47:0] da;
        da = {d[7:0], d[15:8], d[23:16], d[31:24], d[39:32], d[47:40]};
        return (da == LOCAL_MAC) || (ACCEPT_BCAST && (da == 48'hFFFF_FFFF_FFFF));
    endfunction

    function automatic logic [15:0] be16(input logic [7:0] hi, input logic [7:0] lo);
        return {hi, lo};
    endfunction

    logic [15:0] hdr_etype;
    logic [15:0] hdr_seq;
    assign hdr_etype = be16(s_axis_tdata[39:32], s_axis_tdata[47:40]);
    assign hdr_seq   = be16(s_axis_tdata[55:48], s_axis_tdata[63:56]);

    always_ff @(posedge clk156) begin
        if (sys_rst) begin
            state         <= HDR0;
            wr_en         <= 1'b0;
            din           <= '0;
            frm_ok_cnt    <= '0;
            frm_drop_cnt  <= '0;
            seq_err_cnt   <= '0;
            last_seq      <= '0;
            exp_seq       <= '0;
            exp_seq_valid <= 1'b0;
            abort_pend    <= 1'b0;
            da_match      <= 1'b0;
        end else begin
            wr_en <= 1'b0;

            // A pending abort never overlaps a payload write: HDR1 rejects frames while it is set.
            if (abort_pend && !full) begin
                wr_en      <= 1'b1;
                din        <= TERMINATOR;
                abort_pend <= 1'b0;
            end

            if (s_axis_tvalid) begin
                case (state)
                    HDR0: begin
                        da_match <= dest_match(s_axis_tdata);
                        if (s_axis_tlast)
                            frm_drop_cnt <= frm_drop_cnt + 32'd1;
                        else
                            state <= HDR1;
                    end
                    HDR1: begin
                        if (s_axis_tlast) begin
                            frm_drop_cnt <= frm_drop_cnt + 32'd1;
                            state        <= HDR0;
                        end else if (!da_match || hdr_etype != ETHERTYPE || abort_pend) begin
                            frm_drop_cnt <= frm_drop_cnt + 32'd1;
                            state        <= DROP;
                        end else begin
                            state    <= PAYLOAD;
                            last_seq <= hdr_seq;
                            if (exp_seq_valid && hdr_seq != exp_seq)
                                seq_err_cnt <= seq_err_cnt + 16'd1;
                            exp_seq       <= hdr_seq + 16'd1;
                            exp_seq_valid <= 1'b1;
                        end
                    end
                    PAYLOAD: begin
                        if (full) begin
                            abort_pend   <= 1'b1;
                            frm_drop_cnt <= frm_drop_cnt + 32'd1;
                            state        <= s_axis_tlast ? HDR0 : DROP;
                        end else begin
                            wr_en <= 1'b1;
                            din   <= {s_axis_tuser & s_axis_tlast, s_axis_tlast,
                                      s_axis_tkeep, s_axis_tdata};
                            if (s_axis_tlast) begin
                                frm_ok_cnt <= frm_ok_cnt + 32'd1;
                                state      <= HDR0;
                            end
                        end
                    end
                    DROP: begin
                        if (s_axis_tlast)
                            state <= HDR0;
                    end
                    default: state <= HDR0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_eth_tlp_decap.sv
// Directed bench for eth_tlp_decap: builds frames byte by byte and checks FIFO writes and counters.
module tb_eth_tlp_decap;

    logic        clk156 = 1'b0;
    logic        sys_rst;
    logic        s_axis_tvalid;
    logic [63:0] s_axis_tdata;
    logic [7:0]  s_axis_tkeep;
    logic        s_axis_tlast;
    logic        s_axis_tuser;
    logic        wr_en;
    logic [73:0] din;
    logic        full;
    logic [31:0] frm_ok_cnt;
    logic [31:0] frm_drop_cnt;
    logic [15:0] seq_err_cnt;
    logic [15:0] last_seq;

    localparam logic [47:0] MAC_OK  = 48'h00_0A_35_00_00_01;
    localparam logic [47:0] MAC_BAD = 48'h00_0A_35_00_00_02;

    int errors = 0;
    int checks = 0;
    logic [73:0] wr_log[$];
    logic        wr_after[16];
    int          base;

    eth_tlp_decap dut (
        .clk156        (clk156),
        .sys_rst       (sys_rst),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .wr_en         (wr_en),
        .din           (din),
        .full          (full),
        .frm_ok_cnt    (frm_ok_cnt),
        .frm_drop_cnt  (frm_drop_cnt),
        .seq_err_cnt   (seq_err_cnt),
        .last_seq      (last_seq)
    );

    always #5 clk156 = ~clk156;

    always @(negedge clk156)
        if (wr_en) wr_log.push_back(din);

    task automatic check(input string tag, input logic [73:0] act, input logic [73:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk156);
        #1;
    endtask

    task automatic do_reset();
        sys_rst       = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        full          = 1'b0;
        tick();
        tick();
        sys_rst = 1'b0;
        base    = wr_log.size();
    endtask

    task automatic drive_beat(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        s_axis_tuser  = u;
        tick();
    endtask

    // user_mode: 0 none, 1 tuser on tlast, 2 tuser on every beat. full_from: beat that raises full.
    task automatic send_frame(input logic [47:0] da, input logic [15:0] et, input logic [15:0] seq,
                              input int plen, input int trunc, input int user_mode, input int full_from);
        logic [7:0]  fr[$];
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        int n, nb;
        fr = {};
        for (int i = 0; i < 6; i++) fr.push_back(da[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) fr.push_back(8'(8'hA0 + i));
        fr.push_back(et[15:8]);  fr.push_back(et[7:0]);
        fr.push_back(seq[15:8]); fr.push_back(seq[7:0]);
        for (int i = 0; i < plen; i++) fr.push_back(8'(i + 1));
        n  = (trunc > 0) ? trunc : fr.size();
        nb = (n + 7) / 8;
        for (int b = 0; b < nb; b++) begin
            d = '0;
            k = '0;
            for (int j = 0; j < 8; j++)
                if (8*b + j < n) begin
                    d[8*j +: 8] = fr[8*b + j];
                    k[j] = 1'b1;
                end
            l = (b == nb - 1);
            if (full_from >= 0 && b == full_from) full = 1'b1;
            drive_beat(d, k, l, (user_mode == 2) || (user_mode == 1 && l));
            if (b < 16) wr_after[b] = wr_en;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
        tick();
    endtask

    initial begin
        do_reset();
        check("rst_wr_en", 74'(wr_en), 74'd0);
        check("rst_din", din, 74'd0);
        check("rst_ok", 74'(frm_ok_cnt), 74'd0);
        check("rst_drop", 74'(frm_drop_cnt), 74'd0);
        check("rst_seqerr", 74'(seq_err_cnt), 74'd0);
        check("rst_lastseq", 74'(last_seq), 74'd0);

        // T1: 48-byte payload, six full beats
        send_frame(MAC_OK, 16'h88B5, 16'd5, 48, 0, 0, -1);
        check("t1_writes", 74'(wr_log.size() - base), 74'd6);
        check("t1_last_din", wr_log[wr_log.size()-1], {1'b0, 1'b1, 8'hFF, 64'h302F2E2D2C2B2A29});
        check("t1_ok", 74'(frm_ok_cnt), 74'd1);
        check("t1_lastseq", 74'(last_seq), 74'd5);

        // T2: 13-byte payload, partial tail and write latency
        do_reset();
        send_frame(MAC_OK, 16'h88B5, 16'd1, 13, 0, 0, -1);
        check("t2_writes", 74'(wr_log.size() - base), 74'd2);
        check("t2_tail", wr_log[wr_log.size()-1], {1'b0, 1'b1, 8'h1F, 64'h0000000D0C0B0A09});
        check("t2_no_wr_hdr", 74'(wr_after[1]), 74'd0);
        check("t2_wr_after_b2", 74'(wr_after[2]), 74'd1);

        // T3: ethertype, unicast filter, runt; plus broadcast accepted
        do_reset();
        send_frame(MAC_OK, 16'h0800, 16'd1, 16, 0, 0, -1);
        send_frame(MAC_BAD, 16'h88B5, 16'd1, 16, 0, 0, -1);
        send_frame(MAC_OK, 16'h88B5, 16'd1, 16, 8, 0, -1);
        check("t3_writes", 74'(wr_log.size() - base), 74'd0);
        check("t3_drop", 74'(frm_drop_cnt), 74'd3);
        send_frame(48'hFFFF_FFFF_FFFF, 16'h88B5, 16'd9, 8, 0, 0, -1);
        check("t3_bcast_writes", 74'(wr_log.size() - base), 74'd1);
        check("t3_bcast_ok", 74'(frm_ok_cnt), 74'd1);

        // T4: sequence tracking with a gap and a 16-bit wrap
        do_reset();
        send_frame(MAC_OK, 16'h88B5, 16'd7, 8, 0, 0, -1);
        send_frame(MAC_OK, 16'h88B5, 16'd8, 8, 0, 0, -1);
        send_frame(MAC_OK, 16'h88B5, 16'd10, 8, 0, 0, -1);
        send_frame(MAC_OK, 16'h88B5, 16'd11, 8, 0, 0, -1);
        check("t4_seqerr", 74'(seq_err_cnt), 74'd1);
        check("t4_lastseq", 74'(last_seq), 74'd11);
        send_frame(MAC_OK, 16'h88B5, 16'hFFFF, 8, 0, 0, -1);
        send_frame(MAC_OK, 16'h88B5, 16'h0000, 8, 0, 0, -1);
        check("t4_wrap_seqerr", 74'(seq_err_cnt), 74'd2);
        check("t4_wrap_lastseq", 74'(last_seq), 74'd0);
        check("t4_ok", 74'(frm_ok_cnt), 74'd6);

        // T5: overflow on payload beat 3 of 8, frame during full, then terminator
        do_reset();
        send_frame(MAC_OK, 16'h88B5, 16'd1, 64, 0, 0, 4);
        check("t5_writes", 74'(wr_log.size() - base), 74'd2);
        check("t5_drop1", 74'(frm_drop_cnt), 74'd1);
        send_frame(MAC_OK, 16'h88B5, 16'd2, 16, 0, 0, -1);
        check("t5_drop2", 74'(frm_drop_cnt), 74'd2);
        check("t5_no_wr_full", 74'(wr_log.size() - base), 74'd2);
        full = 1'b0;
        tick();
        tick();
        check("t5_term_count", 74'(wr_log.size() - base), 74'd3);
        check("t5_term_din", wr_log[wr_log.size()-1], {2'b11, 72'd0});
        send_frame(MAC_OK, 16'h88B5, 16'd3, 8, 0, 0, -1);
        check("t5_recover_writes", 74'(wr_log.size() - base), 74'd4);
        check("t5_ok", 74'(frm_ok_cnt), 74'd1);

        // T6: tuser forwarded only on tlast, then reset mid-payload
        do_reset();
        send_frame(MAC_OK, 16'h88B5, 16'd4, 16, 0, 2, -1);
        check("t6_writes", 74'(wr_log.size() - base), 74'd2);
        check("t6_user_mid", 74'(wr_log[base][73]), 74'd0);
        check("t6_user_last", 74'(wr_log[wr_log.size()-1][73]), 74'd1);
        check("t6_ok", 74'(frm_ok_cnt), 74'd1);

        drive_beat(64'hA1A0_0100_0035_0A00, 8'hFF, 1'b0, 1'b0);
        drive_beat(64'h0100_B588_A5A4_A3A2, 8'hFF, 1'b0, 1'b0);
        drive_beat(64'h1111_1111_1111_1111, 8'hFF, 1'b0, 1'b0);
        check("t6_pre_rst_wr", 74'(wr_en), 74'd1);
        sys_rst = 1'b1;
        drive_beat(64'h2222_2222_2222_2222, 8'hFF, 1'b0, 1'b0);
        sys_rst = 1'b0;
        check("t6_rst_wr", 74'(wr_en), 74'd0);
        check("t6_rst_ok", 74'(frm_ok_cnt), 74'd0);
        check("t6_rst_lastseq", 74'(last_seq), 74'd0);
        base = wr_log.size();
        drive_beat(64'h3333_3333_3333_3333, 8'hFF, 1'b0, 1'b0);
        drive_beat(64'h4444_4444_4444_4444, 8'hFF, 1'b1, 1'b0);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        tick();
        tick();
        check("t6_tail_drop", 74'(frm_drop_cnt), 74'd1);
        check("t6_tail_nowr", 74'(wr_log.size() - base), 74'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
